key_tick_counter: RTL
=====================

KEY_TICK_COUNTER -- requirements
Module: key_tick_counter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the consecutive stable cycles needed to accept a KEY1 level change (10 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 Parameter HOLD_CYCLES, default 100000000, SHALL set the cycles KEY1 must stay debounced-pressed before a long-press clear (2 s); legal range 2..2^28-1.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous active-high reset.
REQ-005 TICK  input  1  one-cycle count enable from the prescaler; may be asserted on any cycle.
REQ-006 KEY1  input  1  raw push-button, active-low (0 = pressed), asynchronous to CLK.
REQ-007 data  output  8  current count value, feeds hex_display.data.
REQ-008 dir  output  1  count direction; 0 = up, 1 = down.
REQ-009 key_press  output  1  one-cycle pulse per accepted press.
REQ-010 key_hold  output  1  one-cycle pulse when a long-press clear fires.

Function
REQ-011 KEY1 SHALL pass through a 2-flop synchronizer; both flops SHALL reset to 1 (released).
REQ-012 Debounced level kd (reset 1) SHALL change only after the synchronized key differs from kd for DEBOUNCE_CYCLES consecutive cycles; any matching sample SHALL zero the debounce counter.
REQ-013 Latency: a clean KEY1 1->0 step SHALL produce key_press exactly DEBOUNCE_CYCLES+3 rising edges after the first edge sampling KEY1=0.
REQ-014 Press FSM states SHALL be IDLE, PRESSED and HELD; reset state IDLE.
REQ-015 IDLE->PRESSED on kd 1->0: key_press=1 for that cycle, dir toggles, hold counter cleared.
REQ-016 PRESSED: hold counter increments each cycle; when it reaches HOLD_CYCLES-1 the FSM SHALL go to HELD, pulse key_hold, and load data=8'h00.
REQ-017 PRESSED->IDLE or HELD->IDLE on kd 0->1, with no pulse and no change to data or dir.
REQ-018 HELD SHALL not repeat key_hold or clear again until release and a new press.
REQ-019 On TICK=1 with no clear that cycle: data += 1 if dir=0, data -= 1 if dir=1, modulo 256 (8'hFF->8'h00 up, 8'h00->8'hFF down).
REQ-020 TICK and key_press in the same cycle: the count step SHALL use the pre-toggle dir; the new dir applies from the next cycle.
REQ-021 TICK and the long-press clear in the same cycle: the clear wins; data=8'h00 and no step.
REQ-022 key_press and key_hold SHALL never assert in the same cycle.
REQ-023 TICK held high continuously SHALL step data every cycle; no internal edge detection on TICK.

Reset
REQ-024 While RST=1 at a rising edge: data=8'h00, dir=0, key_press=0, key_hold=0, FSM=IDLE, kd=1, synchronizer flops=1, debounce and hold counters=0.
REQ-025 RST SHALL take priority over TICK and KEY1 in the same cycle.
REQ-026 RST asserted mid-press (PRESSED or HELD) SHALL return to IDLE.
REQ-027 After RST, if KEY1 is still low, that press SHALL be accepted normally once debounced (key_press fires, dir->1).

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=16)
REQ-028 Reset, then 300 single-cycle TICKs with KEY1=1 -> data=8'h2C (300 mod 256), dir=0, no key_press.
REQ-029 From data=8'h00, dir=0: clean press -> key_press once, 7 edges after KEY1 falls; dir=1; next TICK -> data=8'hFF.
REQ-030 KEY1 glitches low for 3 cycles, repeated 10 times -> no key_press, kd stays 1, dir unchanged.
REQ-031 From data=8'h35: hold KEY1 low 40 cycles -> one key_press, then one key_hold 16 cycles later; data=8'h00; no second key_hold; release -> FSM IDLE, dir still toggled once.
REQ-032 key_press and TICK coincide with data=8'h10, dir=0 -> data=8'h11 that cycle; dir=1; following TICK -> 8'h10.
REQ-033 RST pulsed during HELD with KEY1 still low -> outputs at reset values; 7 edges later key_press fires and dir=1.

Source files
------------

// File: rtl/key_tick_counter.sv
// Up/down 8-bit tick counter steered by a debounced push-button: a short press
// flips the count direction, holding the button for HOLD_CYCLES clears the count.
module key_tick_counter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 100000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TICK,
  input  logic       KEY1,
  output logic [7:0] data,
  output logic       dir,
  output logic       key_press,
  output logic       key_hold,
  output logic [1:0] state_dbg_o,
  output logic       kd_dbg_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;

  localparam logic [23:0] DEB_LAST  = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [27:0] HOLD_LAST = 28'(HOLD_CYCLES - 1);

  logic        sync1_q, sync2_q;
  logic        kd_q, kd_d;
  logic [23:0] deb_cnt_q, deb_cnt_d;
  logic [27:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]  state_q, state_d;
  logic        key_press_q, key_press_d;
  logic        key_hold_q, key_hold_d;
  logic [7:0]  data_q, data_d;
  logic        dir_q, dir_d;

  // kd only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    kd_d      = kd_q;
    deb_cnt_d = '0;
    if (sync2_q != kd_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        kd_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 24'd1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    key_press_d = 1'b0;
    key_hold_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!kd_q) begin
          state_d     = ST_PRESSED;
          key_press_d = 1'b1;
          hold_cnt_d  = '0;
        end
      end
      ST_PRESSED: begin
        if (kd_q) begin
          state_d = ST_IDLE;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_HELD;
          key_hold_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 28'd1;
        end
      end
      ST_HELD: begin
        if (kd_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The pulse cycles drive the datapath: a step coinciding with key_press still
  // uses the old direction, and a step coinciding with key_hold loses to the clear.
  always_comb begin
    dir_d  = key_press_q ? ~dir_q : dir_q;
    data_d = data_q;
    if (key_hold_q) begin
      data_d = 8'h00;
    end else if (TICK) begin
      data_d = dir_q ? (data_q - 8'd1) : (data_q + 8'd1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      kd_q        <= 1'b1;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      state_q     <= ST_IDLE;
      key_press_q <= 1'b0;
      key_hold_q  <= 1'b0;
      data_q      <= 8'h00;
      dir_q       <= 1'b0;
    end else begin
      sync1_q     <= KEY1;
      sync2_q     <= sync1_q;
      kd_q        <= kd_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      state_q     <= state_d;
      key_press_q <= key_press_d;
      key_hold_q  <= key_hold_d;
      data_q      <= data_d;
      dir_q       <= dir_d;
    end
  end

  assign data        = data_q;
  assign dir         = dir_q;
  assign key_press   = key_press_q;
  assign key_hold    = key_hold_q;
  assign state_dbg_o = state_q;
  assign kd_dbg_o    = kd_q;

endmodule
